vc_mem_copy_engine: RTL

Memory-request initiator that copies a block of words from a source address range to a destination address range. It drives the standard memreq/memresp val/rdy interface of the team's single-port memories: magic zero-latency and test memories with random delay. It accepts one copy command at a time, keeps at most one read outstanding, and signals completion through a done handshake. It sits between a controller (or test source) and one memory port.

---
 rtl/vc_mem_pkg.sv | 16 +
 rtl/vc_mem_copy_ctr.sv | 58 +++++
 rtl/vc_mem_copy_engine.sv | 116 +++++++++++
 3 files changed

// File: rtl/vc_mem_pkg.sv
// Shared memory-request definitions for the vc_mem blocks: request type codes
// and the copy-engine state encoding.
package vc_mem_pkg;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  typedef logic [2:0] copy_state_t;

  localparam copy_state_t IDLE    = 3'd0;
  localparam copy_state_t RD_REQ  = 3'd1;
  localparam copy_state_t RD_WAIT = 3'd2;
  localparam copy_state_t WR_REQ  = 3'd3;
  localparam copy_state_t DONE    = 3'd4;

endpackage

// File: rtl/vc_mem_copy_ctr.sv
// Address/count tracker for the copy engine: source and destination word
// pointers plus the remaining word count.
module vc_mem_copy_ctr #(
  parameter int unsigned ADDR_SZ    = 8,
  parameter int unsigned LEN_SZ     = 8,
  parameter int unsigned ADDR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [ADDR_SZ-1:0] src_i,
  input  logic [ADDR_SZ-1:0] dst_i,
  input  logic [LEN_SZ-1:0]  len_i,
  output logic [ADDR_SZ-1:0] sa_o,
  output logic [ADDR_SZ-1:0] da_o,
  output logic               last_o
);

  localparam logic [ADDR_SZ-1:0] STRIDE = ADDR_SZ'(1 << ADDR_SHIFT);

  logic [ADDR_SZ-1:0] sa_q, sa_d;
  logic [ADDR_SZ-1:0] da_q, da_d;
  logic [LEN_SZ-1:0]  cnt_q, cnt_d;

  // Pointer increments wrap modulo 2^ADDR_SZ by construction.
  always_comb begin
    sa_d  = sa_q;
    da_d  = da_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sa_d  = src_i;
      da_d  = dst_i;
      cnt_d = len_i;
    end else if (advance_i) begin
      sa_d  = sa_q + STRIDE;
      da_d  = da_q + STRIDE;
      cnt_d = cnt_q - LEN_SZ'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sa_q  <= '0;
      da_q  <= '0;
      cnt_q <= '0;
    end else begin
      sa_q  <= sa_d;
      da_q  <= da_d;
      cnt_q <= cnt_d;
    end
  end

  assign sa_o   = sa_q;
  assign da_o   = da_q;
  assign last_o = (cnt_q == LEN_SZ'(1));

endmodule

// File: rtl/vc_mem_copy_engine.sv
// Block-copy memory-request initiator: reads each source word and writes it
// to the destination, one read outstanding at a time, then signals done.
module vc_mem_copy_engine #(
  parameter int unsigned ADDR_SZ    = 8,
  parameter int unsigned DATA_SZ    = 32,
  parameter int unsigned ADDR_SHIFT = 2,
  parameter int unsigned LEN_SZ     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_SZ-1:0] cmd_bits_src,
  input  logic [ADDR_SZ-1:0] cmd_bits_dst,
  input  logic [LEN_SZ-1:0]  cmd_bits_len,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  output logic               done_val,
  input  logic               done_rdy,
  output logic               memreq_bits_rw,
  output logic [ADDR_SZ-1:0] memreq_bits_addr,
  output logic [DATA_SZ-1:0] memreq_bits_data,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [DATA_SZ-1:0] memresp_bits_data,
  input  logic               memresp_val
);

  import vc_mem_pkg::*;

  copy_state_t        state_q, state_d;
  logic [DATA_SZ-1:0] data_q, data_d;
  logic               ctr_load;
  logic               ctr_adv;
  logic [ADDR_SZ-1:0] sa;
  logic [ADDR_SZ-1:0] da;
  logic               last;

  vc_mem_copy_ctr #(
    .ADDR_SZ    (ADDR_SZ),
    .LEN_SZ     (LEN_SZ),
    .ADDR_SHIFT (ADDR_SHIFT)
  ) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ctr_load),
    .advance_i (ctr_adv),
    .src_i     (cmd_bits_src),
    .dst_i     (cmd_bits_dst),
    .len_i     (cmd_bits_len),
    .sa_o      (sa),
    .da_o      (da),
    .last_o    (last)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    ctr_load = 1'b0;
    ctr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_val) begin
          ctr_load = 1'b1;
          state_d  = (cmd_bits_len == '0) ? DONE : RD_REQ;
        end
      end
      // A zero-latency memory answers in the same cycle the read is accepted.
      RD_REQ: begin
        if (memreq_rdy) begin
          if (memresp_val) begin
            data_d  = memresp_bits_data;
            state_d = WR_REQ;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (memresp_val) begin
          data_d  = memresp_bits_data;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (memreq_rdy) begin
          ctr_adv = 1'b1;
          state_d = last ? DONE : RD_REQ;
        end
      end
      DONE: begin
        if (done_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Outputs come from registered state only, held at zero while in reset.
  assign cmd_rdy          = reset && (state_q == IDLE);
  assign done_val         = reset && (state_q == DONE);
  assign memreq_val       = reset && ((state_q == RD_REQ) || (state_q == WR_REQ));
  assign memreq_bits_rw   = (reset && (state_q == WR_REQ)) ? MEM_WR : MEM_RD;
  assign memreq_bits_addr = !reset              ? '0 :
                            (state_q == RD_REQ) ? sa :
                            (state_q == WR_REQ) ? da : '0;
  assign memreq_bits_data = (reset && (state_q == WR_REQ)) ? data_q : '0;

endmodule
